literal_translation_table: RTL and testbench
============================================

# literal_translation_table

Multi-port successor to the literal address translation table. Maps a signed literal index (variable number plus polarity bit) to a clause-table base address and a clause-occurrence mask, serving READ_PORTS independent lookups per cycle. Adds a self-clearing init sweep, per-entry written/valid tracking (hit flag), write-first bypass and an optional output pipeline stage. Sits between the AXI setup path (writes, once per problem) and the clause evaluation pipeline (runtime reads, every cycle).

## Interface
- CLAUSE_COUNT, 20, mask width (clauses per table row)
- LITERAL_ADDRESS_WIDTH, 12, variable index width; entry address is LITERAL_ADDRESS_WIDTH+1 bits (MSB = polarity)
- CLAUSE_TABLE_ADDRESS_WIDTH, 11, width of returned clause-table address
- READ_PORTS, 2, number of independent runtime read channels (>=1)
- OUTPUT_REG, 1, 0 or 1; adds one register stage on all read outputs
- Derived: AW = LITERAL_ADDRESS_WIDTH+1, DEPTH = 2**AW, W = CLAUSE_TABLE_ADDRESS_WIDTH+CLAUSE_COUNT
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- clear_i  in  1  single-cycle request to re-run the clear sweep
- ready_o  out  1  table initialised and accepting writes
- axi_wr_en_i  in  1  write strobe
- axi_wr_addr_i  in  AW  entry address
- axi_wr_data_i  in  W  {clause address, mask}; mask in low CLAUSE_COUNT bits
- wr_drop_o  out  1  pulses one cycle after a write that was discarded
- rd_valid_i  in  READ_PORTS  per-port lookup request
- rd_addr_i  in  READ_PORTS*AW  port p at bits [p*AW +: AW]
- rd_valid_o  out  READ_PORTS  per-port result valid
- rd_hit_o  out  READ_PORTS  entry has been written since last clear
- addr_o  out  READ_PORTS*CLAUSE_TABLE_ADDRESS_WIDTH  per-port clause-table address
- mask_o  out  READ_PORTS*CLAUSE_COUNT  per-port clause mask

## Operation
- FSM states: CLEAR, READY. rst_i forces CLEAR with sweep counter = 0.
- CLEAR: each cycle writes all-zero data and valid=0 to entry[counter], counter++; after entry DEPTH-1 is written, go to READY. ready_o = 0.
- READY: ready_o = 1; axi_wr_en_i writes data and sets valid bit for that entry.
- clear_i in READY: go to CLEAR, counter = 0. clear_i in CLEAR: counter restarts at 0. rst_i has priority over clear_i.
- Writes while not READY (CLEAR, or the cycle clear_i is sampled) are discarded; wr_drop_o = 1 the following cycle.
- Reads always accepted on every port. In CLEAR, results return with data = 0, hit = 0.
- Write-first bypass: write and read to same address in the same READY cycle return the new data with hit = 1, on every port that matches.
- Ports are fully independent; any number may read the same address.
- Output bit slicing: mask = data[CLAUSE_COUNT-1:0], addr = data[W-1:CLAUSE_COUNT].
- No backpressure; consumers must accept results when rd_valid_o is high.

## Timing
- Read latency L = 1 + OUTPUT_REG cycles: request in cycle t -> rd_valid_o/data in cycle t+L.
- rd_valid_o is rd_valid_i delayed L cycles; data/hit on ports with rd_valid_o = 0 hold their previous value.
- Write visible to non-bypassed reads issued in the next cycle.
- Sweep: first cycle with rst_i low clears entry 0; ready_o rises DEPTH cycles after rst_i deasserts. Same from the cycle after clear_i is sampled.
- Reset values: ready_o 0, wr_drop_o 0, rd_valid_o 0, rd_hit_o 0, addr_o 0, mask_o 0; in-flight reads are flushed (no rd_valid_o after reset).
- rst_i mid-sweep: sweep restarts at entry 0 and takes DEPTH cycles again.

## Test plan
- LITERAL_ADDRESS_WIDTH=3 (DEPTH 16), OUTPUT_REG=1: release reset -> ready_o low for exactly 16 cycles then high; reads issued during sweep return hit 0, data 0 at latency 2.
- After ready, write addr 5 = {addr 0x2A, mask 0x00013}; port 0 read addr 5 next cycle -> cycle+2: rd_valid_o[0]=1, addr_o 0x2A, mask_o 0x00013, hit 1; port 1 read addr 6 -> hit 0, data 0.
- Same-cycle write addr 9 = {0x7F, 0xFFFFF} and reads of 9 on both ports -> both return 0x7F/0xFFFFF, hit 1.
- Write while ready_o = 0 -> wr_drop_o high one cycle later, later read of that address returns hit 0.
- Fill entries 0..15, pulse clear_i -> ready_o low 16 cycles; all entries read back hit 0, data 0.
- Assert rst_i with reads in flight and mid-sweep (counter 7) -> no rd_valid_o after reset, ready_o rises 16 cycles after release; repeat with OUTPUT_REG=0 confirming latency 1.

Source files
------------

// File: rtl/literal_translation_table.sv
// Literal -> {clause-table address, clause mask} lookup, READ_PORTS reads/cycle, self-clearing sweep.
// Read latency 1+OUTPUT_REG cycles; no backpressure, writes outside READY are dropped and flagged.
module literal_translation_table #(
  parameter int CLAUSE_COUNT               = 20,
  parameter int LITERAL_ADDRESS_WIDTH      = 12,
  parameter int CLAUSE_TABLE_ADDRESS_WIDTH = 11,
  parameter int READ_PORTS                 = 2,
  parameter int OUTPUT_REG                 = 1
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             clear_i,
  output logic                                             ready_o,
  input  logic                                             axi_wr_en_i,
  input  logic [LITERAL_ADDRESS_WIDTH:0]                   axi_wr_addr_i,
  input  logic [CLAUSE_TABLE_ADDRESS_WIDTH+CLAUSE_COUNT-1:0] axi_wr_data_i,
  output logic                                             wr_drop_o,
  input  logic [READ_PORTS-1:0]                            rd_valid_i,
  input  logic [READ_PORTS*(LITERAL_ADDRESS_WIDTH+1)-1:0]  rd_addr_i,
  output logic [READ_PORTS-1:0]                            rd_valid_o,
  output logic [READ_PORTS-1:0]                            rd_hit_o,
  output logic [READ_PORTS*CLAUSE_TABLE_ADDRESS_WIDTH-1:0] addr_o,
  output logic [READ_PORTS*CLAUSE_COUNT-1:0]               mask_o
);

  localparam int AW    = LITERAL_ADDRESS_WIDTH + 1;
  localparam int DEPTH = 1 << AW;
  localparam int W     = CLAUSE_TABLE_ADDRESS_WIDTH + CLAUSE_COUNT;
  localparam int CC    = CLAUSE_COUNT;
  localparam int CTAW  = CLAUSE_TABLE_ADDRESS_WIDTH;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_sweep_cnt;
  logic            w_sweep_last;
  logic            w_wr_accept;
  logic            r_wr_drop;

  // Each entry is {valid, clause address, mask}; valid drives the hit flag.
  logic [W:0]      r_table [DEPTH];

  logic [W-1:0]            w_lk_dat [READ_PORTS];
  logic [READ_PORTS-1:0]   w_lk_hit;
  logic [AW-1:0]           w_rd_addr;
  logic [W:0]              w_entry;

  logic [READ_PORTS-1:0]   r_s1_vld;
  logic [READ_PORTS-1:0]   r_s1_hit;
  logic [W-1:0]            r_s1_dat [READ_PORTS];

  logic [READ_PORTS-1:0]   w_out_vld;
  logic [READ_PORTS-1:0]   w_out_hit;
  logic [W-1:0]            w_out_dat [READ_PORTS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    ready_o      = 1'b0;
    w_wr_accept  = 1'b0;
    w_sweep_last = (r_sweep_cnt == {AW{1'b1}});
    case (r_state)
      S_CLEAR: begin
        if (!clear_i && w_sweep_last) begin
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        ready_o     = 1'b1;
        w_wr_accept = axi_wr_en_i && !clear_i;
        if (clear_i) begin
          w_state_nxt = S_CLEAR;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Counter parks at 0 while READY so a later sweep always starts at entry 0.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || r_state == S_READY) begin
      r_sweep_cnt <= '0;
    end else begin
      r_sweep_cnt <= r_sweep_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (r_state == S_CLEAR) begin
        r_table[r_sweep_cnt] <= '0;
      end else if (w_wr_accept) begin
        r_table[axi_wr_addr_i] <= {1'b1, axi_wr_data_i};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= axi_wr_en_i && !w_wr_accept;
    end
  end

  assign wr_drop_o = r_wr_drop;

  // A same-cycle accepted write to the looked-up entry wins over the stored copy.
  always_comb begin
    w_rd_addr = '0;
    w_entry   = '0;
    w_lk_hit  = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      w_lk_dat[p] = '0;
      w_rd_addr   = rd_addr_i[p*AW +: AW];
      if (r_state == S_READY) begin
        if (w_wr_accept && (w_rd_addr == axi_wr_addr_i)) begin
          w_lk_dat[p] = axi_wr_data_i;
          w_lk_hit[p] = 1'b1;
        end else begin
          w_entry     = r_table[w_rd_addr];
          w_lk_dat[p] = w_entry[W-1:0];
          w_lk_hit[p] = w_entry[W];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_vld <= '0;
      r_s1_hit <= '0;
      for (int p = 0; p < READ_PORTS; p++) begin
        r_s1_dat[p] <= '0;
      end
    end else begin
      r_s1_vld <= rd_valid_i;
      for (int p = 0; p < READ_PORTS; p++) begin
        if (rd_valid_i[p]) begin
          r_s1_dat[p] <= w_lk_dat[p];
          r_s1_hit[p] <= w_lk_hit[p];
        end
      end
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [READ_PORTS-1:0] r_s2_vld;
      logic [READ_PORTS-1:0] r_s2_hit;
      logic [W-1:0]          r_s2_dat [READ_PORTS];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_s2_vld <= '0;
          r_s2_hit <= '0;
          for (int p = 0; p < READ_PORTS; p++) begin
            r_s2_dat[p] <= '0;
          end
        end else begin
          r_s2_vld <= r_s1_vld;
          for (int p = 0; p < READ_PORTS; p++) begin
            if (r_s1_vld[p]) begin
              r_s2_dat[p] <= r_s1_dat[p];
              r_s2_hit[p] <= r_s1_hit[p];
            end
          end
        end
      end

      always_comb begin
        w_out_vld = r_s2_vld;
        w_out_hit = r_s2_hit;
        for (int p = 0; p < READ_PORTS; p++) begin
          w_out_dat[p] = r_s2_dat[p];
        end
      end
    end else begin : g_noreg
      always_comb begin
        w_out_vld = r_s1_vld;
        w_out_hit = r_s1_hit;
        for (int p = 0; p < READ_PORTS; p++) begin
          w_out_dat[p] = r_s1_dat[p];
        end
      end
    end
  endgenerate

  always_comb begin
    rd_valid_o = w_out_vld;
    rd_hit_o   = w_out_hit;
    addr_o     = '0;
    mask_o     = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      addr_o[p*CTAW +: CTAW] = w_out_dat[p][W-1:CC];
      mask_o[p*CC +: CC]     = w_out_dat[p][CC-1:0];
    end
  end

endmodule

// File: tb/tb_literal_translation_table.sv
// Directed bench: DEPTH-16 table, one instance with the output register and one without, shared stimulus.
module tb_literal_translation_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [30:0] wr_data;
  logic [1:0]  rd_vld;
  logic [7:0]  rd_addr;

  logic        rdy1, drop1, rdy0, drop0;
  logic [1:0]  vld1, hit1, vld0, hit0;
  logic [21:0] addr1, addr0;
  logic [39:0] mask1, mask0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  literal_translation_table #(
    .CLAUSE_COUNT(20), .LITERAL_ADDRESS_WIDTH(3), .CLAUSE_TABLE_ADDRESS_WIDTH(11),
    .READ_PORTS(2), .OUTPUT_REG(1)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .ready_o(rdy1),
    .axi_wr_en_i(wr_en), .axi_wr_addr_i(wr_addr), .axi_wr_data_i(wr_data),
    .wr_drop_o(drop1), .rd_valid_i(rd_vld), .rd_addr_i(rd_addr),
    .rd_valid_o(vld1), .rd_hit_o(hit1), .addr_o(addr1), .mask_o(mask1)
  );

  literal_translation_table #(
    .CLAUSE_COUNT(20), .LITERAL_ADDRESS_WIDTH(3), .CLAUSE_TABLE_ADDRESS_WIDTH(11),
    .READ_PORTS(2), .OUTPUT_REG(0)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .ready_o(rdy0),
    .axi_wr_en_i(wr_en), .axi_wr_addr_i(wr_addr), .axi_wr_data_i(wr_data),
    .wr_drop_o(drop0), .rd_valid_i(rd_vld), .rd_addr_i(rd_addr),
    .rd_valid_o(vld0), .rd_hit_o(hit0), .addr_o(addr0), .mask_o(mask0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // sel=1 checks the registered-output instance, sel=0 the latency-1 instance.
  task automatic chk_res(input string tag, input bit sel, input logic [1:0] ev, input logic [1:0] eh,
                         input logic [10:0] ea0, input logic [19:0] em0,
                         input logic [10:0] ea1, input logic [19:0] em1);
    chk({tag, ".vld"},  64'(sel ? vld1 : vld0),   64'(ev));
    chk({tag, ".hit"},  64'(sel ? hit1 : hit0),   64'(eh));
    chk({tag, ".addr"}, 64'(sel ? addr1 : addr0), 64'({ea1, ea0}));
    chk({tag, ".mask"}, 64'(sel ? mask1 : mask0), 64'({em1, em0}));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_vld = '0; rd_addr = '0;
    tick(); tick(); tick();

    chk("rst.rdy1", 64'(rdy1), 64'd0);
    chk("rst.rdy0", 64'(rdy0), 64'd0);
    chk("rst.drop1", 64'(drop1), 64'd0);
    chk_res("rst1", 1'b1, 2'b00, 2'b00, 11'h0, 20'h0, 11'h0, 20'h0);
    chk_res("rst0", 1'b0, 2'b00, 2'b00, 11'h0, 20'h0, 11'h0, 20'h0);

    // Initial sweep: 16 cycles not ready, reads return zero, a write is dropped.
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("sweep.rdy1", 64'(rdy1), 64'd0);
      chk("sweep.rdy0", 64'(rdy0), 64'd0);
      if (i == 1) chk_res("sweep_rd0", 1'b0, 2'b11, 2'b00, 11'h0, 20'h0, 11'h0, 20'h0);
      if (i == 2) begin
        chk_res("sweep_rd1", 1'b1, 2'b11, 2'b00, 11'h0, 20'h0, 11'h0, 20'h0);
        chk("sweep.vld0_off", 64'(vld0), 64'd0);
      end
      if (i == 5) begin
        chk("sweep.drop1", 64'(drop1), 64'd1);
        chk("sweep.drop0", 64'(drop0), 64'd1);
      end
      if (i == 6) chk("sweep.drop1_end", 64'(drop1), 64'd0);
      rd_vld  = (i == 0) ? 2'b11 : 2'b00;
      rd_addr = {4'd12, 4'd3};
      wr_en   = (i == 4);
      wr_addr = 4'd7;
      wr_data = {11'h055, 20'h12345};
      tick();
    end
    chk("sweep.rdy1_up", 64'(rdy1), 64'd1);
    chk("sweep.rdy0_up", 64'(rdy0), 64'd1);

    // Plain write then read next cycle.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = {11'h02A, 20'h00013};
    tick();
    chk("wr.no_drop", 64'(drop1), 64'd0);
    wr_en = 1'b0; rd_vld = 2'b11; rd_addr = {4'd6, 4'd5};
    tick();
    rd_vld = 2'b00;
    chk_res("wr_rd0", 1'b0, 2'b11, 2'b01, 11'h02A, 20'h00013, 11'h0, 20'h0);
    tick();
    chk_res("wr_rd1", 1'b1, 2'b11, 2'b01, 11'h02A, 20'h00013, 11'h0, 20'h0);

    // Same-cycle write and reads of the same entry on both ports.
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = {11'h07F, 20'hFFFFF};
    rd_vld = 2'b11; rd_addr = {4'd9, 4'd9};
    tick();
    wr_en = 1'b0; rd_vld = 2'b00;
    chk_res("byp0", 1'b0, 2'b11, 2'b11, 11'h07F, 20'hFFFFF, 11'h07F, 20'hFFFFF);
    tick();
    chk_res("byp1", 1'b1, 2'b11, 2'b11, 11'h07F, 20'hFFFFF, 11'h07F, 20'hFFFFF);
    chk_res("hold0", 1'b0, 2'b00, 2'b11, 11'h07F, 20'hFFFFF, 11'h07F, 20'hFFFFF);

    // Entry 7 was written during the sweep and must not be present.
    rd_vld = 2'b11; rd_addr = {4'd9, 4'd7};
    tick();
    rd_vld = 2'b00;
    chk_res("drop_rd0", 1'b0, 2'b11, 2'b10, 11'h0, 20'h0, 11'h07F, 20'hFFFFF);
    tick();
    chk_res("drop_rd1", 1'b1, 2'b11, 2'b10, 11'h0, 20'h0, 11'h07F, 20'hFFFFF);

    // Fill every entry, spot-check both ends.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = {11'(i + 1), 20'(i * 3 + 1)};
      tick();
    end
    wr_en = 1'b0;
    rd_vld = 2'b11; rd_addr = {4'd15, 4'd0};
    tick();
    rd_vld = 2'b00;
    chk_res("fill_rd0", 1'b0, 2'b11, 2'b11, 11'd1, 20'd1, 11'd16, 20'd46);
    tick();

    // Clear sweep; the write sampled together with clear_i is dropped.
    chk("clr.pre_rdy1", 64'(rdy1), 64'd1);
    clr = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = {11'h111, 20'h22222};
    tick();
    clr = 1'b0; wr_en = 1'b0;
    chk("clr.drop1", 64'(drop1), 64'd1);
    for (int i = 0; i < 16; i++) begin
      chk("clr.rdy1", 64'(rdy1), 64'd0);
      chk("clr.rdy0", 64'(rdy0), 64'd0);
      tick();
    end
    chk("clr.rdy1_up", 64'(rdy1), 64'd1);
    for (int a = 0; a < 16; a += 2) begin
      rd_vld = 2'b11; rd_addr = {4'(a + 1), 4'(a)};
      tick();
      rd_vld = 2'b00;
      chk_res("clr_rd0", 1'b0, 2'b11, 2'b00, 11'h0, 20'h0, 11'h0, 20'h0);
      tick();
      chk_res("clr_rd1", 1'b1, 2'b11, 2'b00, 11'h0, 20'h0, 11'h0, 20'h0);
    end

    // Reset at sweep entry 7 with reads in flight.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rd_vld = 2'b11; rd_addr = {4'd2, 4'd1};
    tick();
    chk("mrst.vld0_pre", 64'(vld0), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0; rd_vld = 2'b00;
    chk_res("mrst1", 1'b1, 2'b00, 2'b00, 11'h0, 20'h0, 11'h0, 20'h0);
    chk_res("mrst0", 1'b0, 2'b00, 2'b00, 11'h0, 20'h0, 11'h0, 20'h0);
    for (int i = 0; i < 16; i++) begin
      chk("mrst.rdy1", 64'(rdy1), 64'd0);
      chk("mrst.rdy0", 64'(rdy0), 64'd0);
      chk("mrst.vld1", 64'(vld1), 64'd0);
      chk("mrst.vld0", 64'(vld0), 64'd0);
      tick();
    end
    chk("mrst.rdy1_up", 64'(rdy1), 64'd1);
    chk("mrst.rdy0_up", 64'(rdy0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
